// File: rtl/seq_mult_pkg.sv
// rtl/seq_mult_pkg.sv - shared arithmetic-unit FSM state encoding
// Purpose: state encoding common to the sequential multiplier and divider,
// so control logic and benches can treat both units alike.
// Ports: none (package).
package seq_mult_pkg;

  typedef enum logic [1:0] {
    s_idle = 2'b00,
    s_op   = 2'b01,
    s_done = 2'b10
  } arith_state_t;

endpackage

// File: rtl/seq_mult.sv
// rtl/seq_mult.sv - sequential shift-add unsigned multiplier
// Purpose: computes prod = mcnd * mplr in a fixed W+1 cycles after start,
// using the start/ready/done_tick handshake shared with the divider.
// Ports:
//   clk       - clock, rising edge
//   reset     - synchronous, active-high
//   start     - request a multiply, honoured only while ready
//   mcnd      - W-bit unsigned multiplicand, captured on accepted start
//   mplr      - W-bit unsigned multiplier, captured on accepted start
//   ready     - idle, can accept start
//   done_tick - one-cycle pulse, prod valid
//   prod      - 2W-bit product {ph, pl}
module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int W    = 8,
  parameter int CBIT = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [W-1:0]   mcnd,
  input  logic [W-1:0]   mplr,
  output logic           ready,
  output logic           done_tick,
  output logic [2*W-1:0] prod
);

  arith_state_t    state_reg, state_next;
  logic [W-1:0]    a_reg, a_next;
  logic [W-1:0]    ph_reg, ph_next;
  logic [W-1:0]    pl_reg, pl_next;
  logic [CBIT-1:0] n_reg, n_next;
  logic [W:0]      sum;

  // Carry out of the add lives in sum[W] and lands in ph[W-1] after the shift.
  assign sum = {1'b0, ph_reg} + (pl_reg[0] ? {1'b0, a_reg} : '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= s_idle;
      a_reg     <= '0;
      ph_reg    <= '0;
      pl_reg    <= '0;
      n_reg     <= '0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      ph_reg    <= ph_next;
      pl_reg    <= pl_next;
      n_reg     <= n_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    ph_next    = ph_reg;
    pl_next    = pl_reg;
    n_next     = n_reg;
    ready      = 1'b0;
    done_tick  = 1'b0;
    unique case (state_reg)
      s_idle: begin
        ready = 1'b1;
        if (start) begin
          a_next     = mcnd;
          ph_next    = '0;
          pl_next    = mplr;
          n_next     = CBIT'(W);
          state_next = s_op;
        end
      end
      s_op: begin
        // {ph, pl} <= {sum, pl} >> 1
        ph_next = sum[W:1];
        pl_next = {sum[0], pl_reg[W-1:1]};
        n_next  = n_reg - CBIT'(1);
        if (n_reg == CBIT'(1)) begin
          state_next = s_done;
        end
      end
      s_done: begin
        done_tick  = 1'b1;
        state_next = s_idle;
      end
      default: begin
        state_next = s_idle;
      end
    endcase
  end

  assign prod = {ph_reg, pl_reg};

endmodule

// File: tb/tb_seq_mult.sv
// tb/tb_seq_mult.sv - self-checking bench for seq_mult (W=8 and W=16)
module tb_seq_mult;

  logic        clk = 1'b0;
  logic        reset;
  logic        start8, start16;
  logic [7:0]  mcnd8, mplr8;
  logic [15:0] mcnd16, mplr16;
  logic        ready8, ready16, done8, done16;
  logic [15:0] prod8;
  logic [31:0] prod16;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  seq_mult #(.W(8), .CBIT(4)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .mcnd(mcnd8), .mplr(mplr8),
    .ready(ready8), .done_tick(done8), .prod(prod8)
  );

  seq_mult #(.W(16), .CBIT(5)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .mcnd(mcnd16), .mplr(mplr16),
    .ready(ready16), .done_tick(done16), .prod(prod16)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic drive(input bit wide, input logic [15:0] a, input logic [15:0] b, input logic st);
    if (wide) begin
      mcnd16 = a; mplr16 = b; start16 = st;
    end else begin
      mcnd8 = a[7:0]; mplr8 = b[7:0]; start8 = st;
    end
  endtask

  function automatic logic rdy(input bit wide);
    return wide ? ready16 : ready8;
  endfunction

  function automatic logic dn(input bit wide);
    return wide ? done16 : done8;
  endfunction

  function automatic logic [31:0] prd(input bit wide);
    return wide ? prod16 : {16'h0, prod8};
  endfunction

  // Called at a negedge while the unit is idle. Product model is plain a*b;
  // timing model: done_tick seen W+1 cycles after the accepting edge.
  task automatic run_mult(input bit wide, input logic [15:0] a, input logic [15:0] b,
                          input bit hold, input logic [15:0] a2, input logic [15:0] b2,
                          input string tag);
    int          w;
    int          cyc;
    int          rlow;
    bit          seen;
    logic [31:0] ea, eb, exp;
    w    = wide ? 16 : 8;
    cyc  = 0;
    rlow = 0;
    seen = 1'b0;
    ea   = wide ? {16'h0, a} : {24'h0, a[7:0]};
    eb   = wide ? {16'h0, b} : {24'h0, b[7:0]};
    exp  = ea * eb;
    drive(wide, a, b, 1'b1);
    while (!seen && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) drive(wide, a2, b2, hold);
      if (!rdy(wide)) rlow++;
      if (dn(wide)) seen = 1'b1;
    end
    check({tag, " latency"}, 64'(cyc), 64'(w + 1));
    check({tag, " prod"}, 64'(prd(wide)), 64'(exp));
    check({tag, " ready_low"}, 64'(rlow), 64'(w + 1));
    @(negedge clk);
    check({tag, " ready_after"}, 64'(rdy(wide)), 64'd1);
    check({tag, " done_after"}, 64'(dn(wide)), 64'd0);
    check({tag, " prod_held"}, 64'(prd(wide)), 64'(exp));
  endtask

  initial begin
    int ticks;
    reset = 1'b1;
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    drive(1'b1, 16'h0, 16'h0, 1'b0);
    repeat (2) @(negedge clk);
    check("rst ready8", 64'(ready8), 64'd1);
    check("rst done8", 64'(done8), 64'd0);
    check("rst prod8", 64'(prod8), 64'd0);
    check("rst ready16", 64'(ready16), 64'd1);
    check("rst prod16", 64'(prod16), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run_mult(1'b0, 16'd13, 16'd11, 1'b0, 16'($urandom), 16'($urandom), "13x11");
    run_mult(1'b0, 16'd255, 16'd255, 1'b0, 16'($urandom), 16'($urandom), "255x255");
    run_mult(1'b0, 16'd0, 16'd200, 1'b0, 16'($urandom), 16'($urandom), "0x200");
    run_mult(1'b0, 16'd200, 16'd0, 1'b0, 16'($urandom), 16'($urandom), "200x0");

    // start held high throughout; operands change during op
    run_mult(1'b0, 16'd3, 16'd5, 1'b1, 16'd7, 16'd9, "hold1");
    run_mult(1'b0, 16'd7, 16'd9, 1'b1, 16'd7, 16'd9, "hold2");
    start8 = 1'b0;
    @(negedge clk);

    // reset wins over start on the same edge
    drive(1'b0, 16'd5, 16'd5, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_prio ready", 64'(ready8), 64'd1);
    reset  = 1'b0;
    start8 = 1'b0;
    @(negedge clk);

    // abort in the 4th op cycle
    drive(1'b0, 16'd100, 16'd100, 1'b1);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort ready", 64'(ready8), 64'd1);
    check("abort prod", 64'(prod8), 64'd0);
    check("abort done", 64'(done8), 64'd0);
    ticks = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) ticks++;
    end
    check("abort no_done", 64'(ticks), 64'd0);
    run_mult(1'b0, 16'd6, 16'd7, 1'b0, 16'($urandom), 16'($urandom), "6x7");

    for (int i = 0; i < 16; i++) begin
      run_mult(1'b0, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)), 1'b0,
               16'($urandom), 16'($urandom), "rand8");
    end

    run_mult(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 16'($urandom), 16'($urandom), "w16 max");
    for (int i = 0; i < 6; i++) begin
      run_mult(1'b1, 16'($urandom), 16'($urandom), 1'b0,
               16'($urandom), 16'($urandom), "rand16");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
